instr_fetch_unit: RTL and testbench

//   Fetch stage directly upstream of the IF/ID pipeline register.
//   - Holds the PC/nPC pair, issues word fetches to instruction memory over a req/ready handshake,
//     and presents {if_instr, if_pc, if_valid} for IF/ID to capture when le=1.
//   - Implements delayed-branch semantics: the instruction after a taken branch always executes.

---
 rtl/ppu_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 24 ++
 rtl/pc_npc_reg.sv | 28 ++
 rtl/instr_fetch_unit.sv | 136 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/ppu_pkg.sv
// Shared types and defaults for the pipeline front end: widths, reset/bubble words,
// fetch FSM states and the buffered fetch word.
package ppu_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEF = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_word_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/ready handshake; master is the fetch unit, slave is the memory.
interface instr_fetch_unit_if;
    import ppu_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );

endinterface

// File: rtl/pc_npc_reg.sv
// PC/nPC pair: on advance the PC takes nPC, and nPC takes either the redirect target
// (giving one delay slot) or the next sequential word.
module pc_npc_reg
    import ppu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              advance,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] npc;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= RESET_PC;
            npc <= RESET_PC + ADDR_W'(4);
        end else if (advance) begin
            pc  <= npc;
            npc <= redirect_en ? redirect_target : npc + ADDR_W'(4);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding IF/ID with delayed-branch redirect handling.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault and parks fetch.
module instr_fetch_unit
    import ppu_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEF,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      le,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_target,
    instr_fetch_unit_if.master        imem,
    output logic [INSTR_W-1:0]        if_instr,
    output logic [ADDR_W-1:0]         if_pc,
    output logic                      if_valid,
    output logic                      fetch_fault
);

    fetch_state_t      state;
    logic              req_q;
    fetch_word_t       hold_buf;
    logic              hold_full;
    logic              redirect_pend;
    logic [ADDR_W-1:0] pend_target;
    logic              fault_q;

    logic              advance;
    logic              redir_take;
    logic [ADDR_W-1:0] redir_raw;
    logic [ADDR_W-1:0] redir_tgt;
    logic              redir_misaligned;
    logic [ADDR_W-1:0] pc;

    // A redirect arriving in the same cycle as an advance is consumed immediately (last wins).
    assign advance    = (state == FETCH) && req_q && imem.imem_ready;
    assign redir_take = redirect_valid || redirect_pend;
    assign redir_raw  = redirect_valid ? redirect_target : pend_target;
    assign redir_tgt  = redir_raw & ~ADDR_W'(3);

`ifdef FETCH_ALIGN_CHECK_EN
    assign redir_misaligned = advance && redir_take && (redir_raw[1:0] != 2'b00);
`else
    assign redir_misaligned = 1'b0;
`endif

    pc_npc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_npc_reg (
        .clk             (clk),
        .reset           (reset),
        .advance         (advance),
        .redirect_en     (redir_take),
        .redirect_target (redir_tgt),
        .pc              (pc)
    );

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc;
    assign fetch_fault    = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= FETCH;
            req_q         <= 1'b0;
            if_instr      <= NOP_WORD;
            if_pc         <= '0;
            if_valid      <= 1'b0;
            fault_q       <= 1'b0;
            redirect_pend <= 1'b0;
            pend_target   <= '0;
            hold_buf      <= '0;
            hold_full     <= 1'b0;
        end else begin
            if (advance) begin
                redirect_pend <= 1'b0;
            end else if (redirect_valid) begin
                redirect_pend <= 1'b1;
                pend_target   <= redirect_target;
            end
            if (redir_misaligned) begin
                fault_q <= 1'b1;
            end

            case (state)
                FETCH: begin
                    req_q <= 1'b1;
                    if (advance) begin
                        if (le) begin
                            if_instr <= imem.imem_rdata;
                            if_pc    <= pc;
                            if_valid <= 1'b1;
                            // With a fault pending, this word is the delay slot; park afterwards.
                            if (fault_q) begin
                                state <= HOLD;
                                req_q <= 1'b0;
                            end
                        end else begin
                            hold_buf  <= '{instr: imem.imem_rdata, pc: pc};
                            hold_full <= 1'b1;
                            state     <= HOLD;
                            req_q     <= 1'b0;
                        end
                    end else if (le) begin
                        if_instr <= NOP_WORD;
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    req_q <= 1'b0;
                    if (le) begin
                        if (hold_full) begin
                            if_instr  <= hold_buf.instr;
                            if_pc     <= hold_buf.pc;
                            if_valid  <= 1'b1;
                            hold_full <= 1'b0;
                            if (!fault_q) begin
                                state <= FETCH;
                                req_q <= 1'b1;
                            end
                        end else begin
                            if_instr <= NOP_WORD;
                            if_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= FETCH;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a cycle table covering streaming, stall/hold,
// delayed branches, memory wait with pending redirect and PC wrap, then reset and alignment sequences.
module tb_instr_fetch_unit;
    import ppu_pkg::*;

    localparam logic [31:0] KEY = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        le = 1'b1;
    logic        rv = 1'b0;
    logic [31:0] tgt = 32'h0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        fetch_fault;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_unit_if imem ();

    // Memory model: each word is its own address scrambled by a constant key.
    assign imem.imem_rdata = imem.imem_addr ^ KEY;

    instr_fetch_unit dut (
        .clk             (clk),
        .reset           (reset),
        .le              (le),
        .redirect_valid  (rv),
        .redirect_target (tgt),
        .imem            (imem),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_valid        (if_valid),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        le;
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        chk_pc;
        logic [31:0] pc;
    } vec_t;

    vec_t vt [26];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                             input logic chk_addr, input logic exp_valid, input logic chk_pc,
                             input logic [31:0] exp_pc, input logic exp_fault);
        check32({tag, " imem_req"}, 32'(imem.imem_req), 32'(exp_req));
        if (chk_addr) check32({tag, " imem_addr"}, imem.imem_addr, exp_addr);
        check32({tag, " if_valid"}, 32'(if_valid), 32'(exp_valid));
        check32({tag, " if_instr"}, if_instr, exp_valid ? (exp_pc ^ KEY) : NOP_WORD_DEF);
        if (chk_pc) check32({tag, " if_pc"}, if_pc, exp_pc);
        check32({tag, " fetch_fault"}, 32'(fetch_fault), 32'(exp_fault));
    endtask

    initial begin
        logic fault_on;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_on = 1'b1;
`else
        fault_on = 1'b0;
`endif
        //          le    rdy   rv    tgt            req   addr           valid chk   if_pc
        vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 32'h0};
        vt[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b0, 1'b1, 32'h0};
        vt[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 1'b1, 32'h0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         1'b1, 1'b1, 32'h4};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC,         1'b1, 1'b1, 32'h4};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC,         1'b1, 1'b1, 32'h4};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'hC,         1'b1, 1'b1, 32'h4};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         1'b1, 1'b1, 32'h8};
        vt[8]  = '{1'b1, 1'b1, 1'b1, 32'h40,        1'b1, 32'h10,        1'b1, 1'b1, 32'hC};
        vt[9]  = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h14,        1'b1, 1'b1, 32'h10};
        vt[10] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h40,        1'b1, 1'b1, 32'h14};
        vt[11] = '{1'b1, 1'b1, 1'b1, 32'h20,        1'b1, 32'h44,        1'b1, 1'b1, 32'h40};
        vt[12] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h48,        1'b1, 1'b1, 32'h44};
        vt[13] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h20,        1'b1, 1'b1, 32'h48};
        vt[14] = '{1'b1, 1'b0, 1'b1, 32'h80,        1'b1, 32'h20,        1'b0, 1'b0, 32'h0};
        vt[15] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h20,        1'b0, 1'b0, 32'h0};
        vt[16] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h20,        1'b0, 1'b0, 32'h0};
        vt[17] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h20,        1'b0, 1'b0, 32'h0};
        vt[18] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h24,        1'b1, 1'b1, 32'h20};
        vt[19] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h80,        1'b1, 1'b1, 32'h24};
        vt[20] = '{1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 32'h84,        1'b1, 1'b1, 32'h80};
        vt[21] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h88,        1'b1, 1'b1, 32'h84};
        vt[22] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1, 32'h88};
        vt[23] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFF8};
        vt[24] = '{1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC};
        vt[25] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h4,         1'b1, 1'b1, 32'h0};

        imem.imem_ready = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        // Outputs are registered, so each row's expectations hold before its edge.
        for (int i = 0; i < 26; i++) begin
            le              = vt[i].le;
            imem.imem_ready = vt[i].rdy;
            rv              = vt[i].rv;
            tgt             = vt[i].tgt;
            check_out($sformatf("v%0d", i), vt[i].req, vt[i].addr, 1'b1, vt[i].valid,
                      vt[i].chk_pc, vt[i].pc, 1'b0);
            tick();
        end
        rv = 1'b0;

        // Memory still waiting: address held, bubble presented.
        check_out("wait", 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);

        // Reset mid-wait abandons the request.
        reset = 1'b1;
        tick();
        check_out("rst_mid", 1'b0, RESET_PC_DEF, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
        reset = 1'b0;
        imem.imem_ready = 1'b1;
        tick();
        check_out("rst_rel", 1'b1, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);

        // Misaligned redirect target 0x42 issued while fetching 0x0; 0x4 is the delay slot.
        rv  = 1'b1;
        tgt = 32'h42;
        tick();
        rv  = 1'b0;
        tgt = 32'h0;
        check_out("mis_a", 1'b1, 32'h4, 1'b1, 1'b1, 1'b1, 32'h0, fault_on);
        tick();
        check_out("mis_b", !fault_on, 32'h40, !fault_on, 1'b1, 1'b1, 32'h4, fault_on);
        tick();
        if (fault_on) begin
            check_out("mis_c", 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end else begin
            check_out("mis_c", 1'b1, 32'h44, 1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
        end
        tick();
        if (fault_on) begin
            check_out("mis_d", 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end else begin
            check_out("mis_d", 1'b1, 32'h48, 1'b1, 1'b1, 1'b1, 32'h44, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
